prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
// Byte-stream program loader: the writing end of the CPU's 256x8 unified memory. Receives a framed byte stream
// on a valid/ready port and writes the payload into memory via the memory write port. Holds the pipelined CPU
// in reset while loading and releases it only after a frame passes its checksum.
// Sits between the host/bench byte source and the CPU wrapper's memory + reset inputs.
// PARAMETERS
// SYNC_BYTE      8'hA5  frame start marker
// RELEASE_DELAY  4      cycles cpu_rstn stays low after checksum pass (1..15)
// PORTS
// clk        in   1  system clock, rising edge
// rstn       in   1  asynchronous active-low reset
// in_data    in   8  stream byte
// in_valid   in   1  in_data valid
// in_ready   out  1  loader accepts; byte transfers when in_valid & in_ready at posedge
// reload     in   1  1-cycle pulse: abort/restart, force CPU back into reset
// mem_we     out  1  memory write strobe (1 cycle per payload byte)
// mem_addr   out  8  memory write address
// mem_wdata  out  8  memory write data
// cpu_rstn   out  1  reset to CPU wrapper, active low
// done       out  1  frame loaded and CPU released (sticky until reload/rstn)
// err        out  1  last frame failed checksum (sticky until next SYNC_BYTE, reload, or rstn)
// BEHAVIOUR
// - Reset (rstn=0, async): state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rstn=0, done=0, err=0.
//   in_ready goes high on the first clock after rstn rises. All outputs registered.
// - Frame: SYNC_BYTE, START (8b address), LEN (8b; 0 means 256), LEN payload bytes, CSUM. CSUM = sum of payload mod 256.
// - FSM: IDLE -> ADDR -> LEN -> DATA -> CSUM -> RELEASE -> DONE; CSUM mismatch -> ERR.
//   IDLE: in_ready=1; non-sync bytes discarded; SYNC_BYTE -> ADDR, clears err.
//   ADDR: accepted byte loads pointer. LEN: accepted byte loads count (0 -> 256, 9-bit counter).
//   DATA: each accepted byte: next cycle mem_we=1, mem_addr=pointer, mem_wdata=byte; pointer+1 mod 256
//     (0xFF wraps to 0x00); running sum += byte mod 256; count-1; after last byte -> CSUM.
//     in_valid gaps allowed; no write without a transfer. Write latency exactly 1 cycle after acceptance.
//   CSUM: accepted byte == sum -> RELEASE, else -> ERR. Sync value inside a frame is ordinary data.
//   RELEASE: in_ready=0, cpu_rstn=0 for RELEASE_DELAY cycles, then DONE.
//   DONE: cpu_rstn=1, done=1, in_ready=0; stays until reload or rstn.
//   ERR: err=1, cpu_rstn=0, in_ready=1; behaves as IDLE (SYNC_BYTE -> ADDR, clears err).
// - reload (any state): next cycle -> IDLE, cpu_rstn=0, done=0, err=0, mem_we=0; a byte offered in the
//   same cycle is not accepted (in_ready=0 that cycle is not required; the byte is dropped).
// - Memory already written by an aborted/erroneous frame is not restored.
// - cpu_rstn never glitches high outside DONE.
// TESTING
// 1. Reset, stream A5 02 02 C5 F0 B5 -> mem[2]=C5, mem[3]=F0, done=1, err=0; cpu_rstn rises 4 cycles after CSUM accepted.
// 2. Stream A5 02 02 C5 F0 00 (bad CSUM) -> err=1, done=0, cpu_rstn=0; then resend good frame -> err clears, done=1.
// 3. Stream A5 FE 03 11 22 33 66 -> writes FE=11, FF=22, 00=33 (wrap); done=1.
// 4. Stream 00 3C A5 10 00 + 256 bytes of 01 + CSUM 00 -> garbage ignored; 256 writes at 10..0F; done=1.
// 5. rstn=0 asserted mid-DATA -> all outputs at reset values immediately; next full frame loads normally.
// 6. reload pulse while DONE -> cpu_rstn=0, done=0 next cycle, in_ready=1; random in_valid gaps in frame 1 -> same result.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
// The host drives the stream through the master modport and the loader takes the slave side.
interface prog_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes payload into CPU memory and holds the CPU in reset
// until a frame with a matching checksum has been fully received.
module prog_loader #(
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         RELEASE_DELAY = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reload,
  prog_loader_if.slave      bus,
  output logic              cpu_rstn,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADDR    = 3'd1;
  localparam logic [2:0] LEN     = 3'd2;
  localparam logic [2:0] DATA    = 3'd3;
  localparam logic [2:0] CSUM    = 3'd4;
  localparam logic [2:0] RELEASE = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  localparam logic [2:0] ERR     = 3'd7;

  localparam logic [3:0] DLY_INIT = 4'(RELEASE_DELAY - 1);

  logic [2:0] state_q,     state_d;
  logic [7:0] ptr_q,       ptr_d;
  logic [8:0] cnt_q,       cnt_d;
  logic [7:0] sum_q,       sum_d;
  logic [3:0] dly_q,       dly_d;
  logic       in_ready_q,  in_ready_d;
  logic       mem_we_q,    mem_we_d;
  logic [7:0] mem_addr_q,  mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       cpu_rstn_q,  cpu_rstn_d;
  logic       done_q,      done_d;
  logic       err_q,       err_d;
  logic       xfer;

  assign xfer = bus.in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    dly_d       = dly_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rstn_d  = cpu_rstn_q;
    done_d      = done_q;
    err_d       = err_q;

    // reload overrides everything, including a byte offered in the same cycle
    if (reload) begin
      state_d    = IDLE;
      cpu_rstn_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE, ERR: begin
          if (xfer && bus.in_data == SYNC_BYTE) begin
            state_d = ADDR;
            err_d   = 1'b0;
            sum_d   = 8'd0;
          end
        end
        ADDR: begin
          if (xfer) begin
            ptr_d   = bus.in_data;
            state_d = LEN;
          end
        end
        LEN: begin
          if (xfer) begin
            cnt_d   = (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
            state_d = DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = bus.in_data;
            ptr_d       = ptr_q + 8'd1;
            sum_d       = sum_q + bus.in_data;
            cnt_d       = cnt_q - 9'd1;
            if (cnt_q == 9'd1) state_d = CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            if (bus.in_data == sum_q) begin
              state_d = RELEASE;
              dly_d   = DLY_INIT;
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
            end
          end
        end
        RELEASE: begin
          if (dly_q == 4'd0) begin
            state_d    = DONE;
            cpu_rstn_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            dly_d = dly_q - 4'd1;
          end
        end
        default: ;
      endcase
    end

    in_ready_d = (state_d != RELEASE) && (state_d != DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= 8'd0;
      cnt_q       <= 9'd0;
      sum_q       <= 8'd0;
      dly_q       <= 4'd0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 8'd0;
      mem_wdata_q <= 8'd0;
      cpu_rstn_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      dly_q       <= dly_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rstn_q  <= cpu_rstn_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rstn      = cpu_rstn_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
